// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, NOP encoding, opcode field, reset PC.
package cpu_pkg;

    localparam logic [31:0] NOP              = 32'h0000_0000;
    localparam int          OPCODE_MSB       = 31;
    localparam int          OPCODE_LSB       = 26;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HELD  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: imem req/ack channel, hazard/redirect inputs, IF/ID outputs.
interface fetch_stage_if #(
    parameter int PC_WIDTH = 32
) ();

    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_ack;
    logic [31:0]         imem_rdata;
    logic                stall;
    logic                branch_taken;
    logic [PC_WIDTH-1:0] branch_target;
    logic                jump;
    logic [PC_WIDTH-1:0] jump_target;
    logic [31:0]         if_id_instr;
    logic [PC_WIDTH-1:0] if_id_pc4;
    logic                if_id_valid;
    logic [5:0]          opcode;

    // Fetch stage side
    modport master (
        output imem_req, imem_addr, if_id_instr, if_id_pc4, if_id_valid, opcode,
        input  imem_ack, imem_rdata, stall, branch_taken, branch_target, jump, jump_target
    );

    // Memory / pipeline environment side
    modport slave (
        input  imem_req, imem_addr, if_id_instr, if_id_pc4, if_id_valid, opcode,
        output imem_ack, imem_rdata, stall, branch_taken, branch_target, jump, jump_target
    );

endinterface

// File: rtl/fetch_buffer.sv
// One-entry holding register for a word that arrived while decode was stalled.
module fetch_buffer #(
    parameter int PC_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_load,
    input  logic                i_clear,
    input  logic [31:0]         i_instr,
    input  logic [PC_WIDTH-1:0] i_pc4,
    output logic                o_full,
    output logic [31:0]         o_instr,
    output logic [PC_WIDTH-1:0] o_pc4
);

    // Clear wins over load so a redirect always empties the entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_full  <= 1'b0;
            o_instr <= '0;
            o_pc4   <= '0;
        end else if (i_clear) begin
            o_full  <= 1'b0;
        end else if (i_load) begin
            o_full  <= 1'b1;
            o_instr <= i_instr;
            o_pc4   <= i_pc4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, imem req/ack, stall buffering, redirect with ack drop, IF/ID register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

    fetch_state_e        r_state, w_state_nx;
    logic [PC_WIDTH-1:0] r_pc, r_pending_pc, r_pc4;
    logic                r_drop, r_valid;
    logic [31:0]         r_instr;

    logic                w_redir, w_ack, w_take, w_to_ifid, w_to_buf, w_buf_drain, w_buf_clear;
    logic [PC_WIDTH-1:0] w_target, w_pc_inc, w_buf_pc4;
    logic [31:0]         w_buf_instr;
    logic                w_buf_full;

    // Branch is older than jump, so it wins; targets are word aligned
    assign w_redir     = bus.branch_taken | bus.jump;
    assign w_target    = bus.branch_taken ? {bus.branch_target[PC_WIDTH-1:2], 2'b00}
                                          : {bus.jump_target[PC_WIDTH-1:2], 2'b00};
    assign w_ack       = (r_state == FETCH) && bus.imem_ack;
    assign w_pc_inc    = r_pc + PC_WIDTH'(4);
    // A word is kept only if it belongs to the current path
    assign w_take      = w_ack && !r_drop && !w_redir;
    assign w_to_ifid   = w_take && !bus.stall;
    assign w_to_buf    = w_take && bus.stall;
    assign w_buf_drain = (r_state == HELD) && !bus.stall && !w_redir && w_buf_full;
    assign w_buf_clear = w_redir || w_buf_drain;

    fetch_buffer #(.PC_WIDTH(PC_WIDTH)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_to_buf),
        .i_clear (w_buf_clear),
        .i_instr (bus.imem_rdata),
        .i_pc4   (w_pc_inc),
        .o_full  (w_buf_full),
        .o_instr (w_buf_instr),
        .o_pc4   (w_buf_pc4)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= BOOT;
        else        r_state <= w_state_nx;
    end

    // Next state: redirect always returns to FETCH
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            BOOT:    w_state_nx = FETCH;
            FETCH:   if (w_to_buf) w_state_nx = HELD;
            HELD:    if (w_redir || !bus.stall) w_state_nx = FETCH;
            default: w_state_nx = BOOT;
        endcase
    end

    // Outputs: request only in FETCH, address held until ack
    always_comb begin
        bus.imem_req  = (r_state == FETCH);
        bus.imem_addr = {r_pc[PC_WIDTH-1:2], 2'b00};
    end

    // PC, pending redirect target and drop flag for an in-flight wrong-path ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc         <= RESET_PC;
            r_pending_pc <= RESET_PC;
            r_drop       <= 1'b0;
        end else if (w_redir) begin
            r_pending_pc <= w_target;
            if ((r_state == FETCH) && !bus.imem_ack) begin
                r_drop <= 1'b1;
            end else begin
                r_drop <= 1'b0;
                r_pc   <= w_target;
            end
        end else if (r_drop && w_ack) begin
            r_drop <= 1'b0;
            r_pc   <= r_pending_pc;
        end else if (w_take) begin
            r_pc <= w_pc_inc;
        end
    end

    // IF/ID register: redirect flushes, stall holds, otherwise bubble when nothing new
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr <= NOP;
            r_pc4   <= '0;
            r_valid <= 1'b0;
        end else if (w_redir) begin
            r_instr <= NOP;
            r_valid <= 1'b0;
        end else if (w_to_ifid) begin
            r_instr <= bus.imem_rdata;
            r_pc4   <= w_pc_inc;
            r_valid <= 1'b1;
        end else if (w_buf_drain) begin
            r_instr <= w_buf_instr;
            r_pc4   <= w_buf_pc4;
            r_valid <= 1'b1;
        end else if (!bus.stall) begin
            r_instr <= NOP;
            r_valid <= 1'b0;
        end
    end

    assign bus.if_id_instr = r_instr;
    assign bus.if_id_pc4   = r_pc4;
    assign bus.if_id_valid = r_valid;
    assign bus.opcode      = r_instr[OPCODE_MSB:OPCODE_LSB];

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the main control decoder. Holds the PC, runs a req/ack handshake with instruction memory, and drives the IF/ID pipeline register, whose top six bits are the opcode the decoder consumes. Absorbs variable memory latency, decode-stage stalls and branch/jump redirects without losing or duplicating instructions.

## Interface
- PC_WIDTH, 32, PC and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  fetch request.
- imem_addr  out  PC_WIDTH  fetch address.
- imem_ack  in  1  data valid this cycle; may arrive in the same cycle as the request.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- stall  in  1  hazard stall: hold IF/ID and PC.
- branch_taken  in  1  redirect to branch_target; older than jump.
- branch_target  in  PC_WIDTH  branch destination.
- jump  in  1  redirect to jump_target.
- jump_target  in  PC_WIDTH  fully formed jump destination.
- if_id_instr  out  32  registered instruction.
- if_id_pc4  out  PC_WIDTH  registered PC+4 of that instruction.
- if_id_valid  out  1  if_id_instr is real, not a bubble.
- opcode  out  6  if_id_instr[31:26], to the control decoder.

## Operation
- States: BOOT (one cycle after reset release, req low), FETCH (req high, addr = PC, waiting for ack), HELD (buffer full while stalled, req low).
- FETCH: imem_addr stays stable until ack. On ack, with no stall and no drop: IF/ID <= {rdata, PC+4, valid=1}, PC <= PC+4, req remains high for the next fetch.
- Ack while stall=1: word goes to a one-entry buffer, go to HELD, PC <= PC+4. IF/ID is unchanged.
- HELD and stall falls: buffer -> IF/ID, buffer cleared, -> FETCH on the next cycle.
- Stall with no ack: IF/ID holds, the request stays outstanding.
- Redirect (branch_taken or jump) overrides stall. Priority: branch_taken over jump. Effects:
  - IF/ID valid <= 0, instr <= NOP (32'h0).
  - Buffer cleared.
  - Redirect target saved in pending_pc.
  - If a request is outstanding without ack this cycle, set drop. The eventual ack is discarded, then PC <= pending_pc and FETCH restarts.
  - Otherwise PC <= target immediately.
- A redirect while drop is already set overwrites pending_pc, so the last redirect wins.
- Arithmetic: PC+4 is modulo 2^PC_WIDTH, so 0xFFFF_FFFC wraps to 0. Low two address bits are always driven 0.
- Bubble cycles (no new word and no stall): IF/ID valid <= 0, instr <= NOP.

## Timing
- Reset values (asynchronous, on rst_n low): imem_req=0, imem_addr=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, opcode=0, state=BOOT, drop=0, buffer empty.
- The first request is issued in the first cycle after BOOT.
- Zero-wait memory: one instruction per cycle. Ack to if_id_valid is one clock edge.
- N-cycle memory: one instruction every N cycles.
- Redirect to first request at the new target: next cycle, or the cycle after the dropped ack.
- rst_n low mid-operation: all outputs go to reset values immediately. The outstanding request is abandoned.

## Structure
- Shared package cpu_pkg holds:
  - NOP constant 32'h0.
  - OPCODE_MSB/LSB = 31/26.
  - fetch state enum {BOOT, FETCH, HELD}.
  - Default RESET_PC.
- One natural sub-module: fetch_buffer, a one-entry instruction/PC+4 holding register with load/clear/full.

## Test plan
- Reset release with zero-wait memory returning 0x8C08_0004 at addr 0: req at cycle 1, addr 0x0. Next edge: if_id_instr=0x8C08_0004, pc4=4, opcode=35, valid=1. Addresses then step 4, 8, 12 in consecutive cycles.
- 3-cycle ack latency: addr is stable for 3 cycles per fetch, valid pulses once every 3 cycles, no duplicate instructions.
- stall held 2 cycles while ack arrives in the first cycle: IF/ID unchanged and state HELD. After release, the buffered word appears in IF/ID, and the next fetch addr is the old PC+4.
- branch_taken with target 0x40 while a fetch to 0x10 is outstanding: the 0x10 data is never in IF/ID, the next request addr is 0x40, and valid=0 in the bubble cycle.
- branch_taken (0x80) and jump (0x200) in the same cycle: the next request addr is 0x80.
- PC=0xFFFF_FFFC fetch then rst_n pulsed low mid-wait: the wrap gives next addr 0x0. The reset pulse forces req=0, valid=0 and opcode=0 immediately.
